// File: rtl/text_vga_pkg.sv
// Shared geometry, address widths and colour constants for the text-mode video path.
package text_vga_pkg;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int TEXT_ADDR_W = 12;
    localparam int FONT_ADDR_W = 11;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t COLOR_BLACK = 12'h000;
    localparam rgb444_t COLOR_WHITE = 12'hFFF;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a programmable reset value; keeps side-band
// signals in step with the pixel datapath.
module sync_delay_line #(
    parameter int                 STAGES  = 3,
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] taps_d [STAGES];
    logic [DATA_W-1:0] taps_q [STAGES];

    always_comb begin
        taps_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            taps_d[i] = taps_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                taps_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                taps_q[i] <= taps_d[i];
            end
        end
    end

    assign dout = taps_q[STAGES-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: coordinate -> text RAM -> font ROM -> RGB, 3-clk latency.
// Optional blinking underline cursor is built when TEXT_CURSOR_EN is defined.
module text_pixel_gen
    import text_vga_pkg::*;
#(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter rgb444_t     FG_COLOR     = COLOR_WHITE,
    parameter rgb444_t     BG_COLOR     = COLOR_BLACK,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   video_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    output logic [TEXT_ADDR_W-1:0] text_addr,
    input  logic [6:0]             text_data,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [7:0]             font_data,
    input  logic [6:0]             cursor_col,
    input  logic [4:0]             cursor_row,
    output logic [11:0]            rgb,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    localparam int BIT_W = $clog2(CHAR_W);
    localparam int ROW_W = $clog2(CHAR_H);

    function automatic rgb444_t shade(input logic vld, input logic in_area, input logic lit);
        if (!vld)          return COLOR_BLACK;
        else if (!in_area) return BG_COLOR;
        else               return lit ? FG_COLOR : BG_COLOR;
    endfunction

    logic [6:0]             col;
    logic [4:0]             row;
    logic [TEXT_ADDR_W-1:0] text_addr_d, text_addr_q;
    logic                   in_area_p0_d, in_area_p0_q, in_area_p1_q;
    logic [ROW_W-1:0]       glyph_row_p0_d, glyph_row_p0_q;
    logic [FONT_ADDR_W-1:0] font_addr_d, font_addr_q;
    logic                   vld_p1;
    logic [BIT_W-1:0]       bit_idx_p1;
    logic [1:0]             sync_out;
    rgb444_t                rgb_d, rgb_q;
    logic                   cursor_on;
    logic                   unused_bits;

    assign col = pixel_x[9 -: 7];
    assign row = pixel_y[ROW_W +: 5];

    always_comb begin
        // S0: cell lookup
        text_addr_d    = TEXT_ADDR_W'(row) * TEXT_ADDR_W'(COLS) + TEXT_ADDR_W'(col);
        in_area_p0_d   = (32'(col) < COLS) && (32'(row) < ROWS) && video_on;
        glyph_row_p0_d = pixel_y[ROW_W-1:0];
        // S1: character code -> font row address
        font_addr_d    = {text_data, glyph_row_p0_q};
        // S2: glyph bit -> colour
        rgb_d          = shade(vld_p1, in_area_p1_q,
                               font_data[3'(CHAR_W - 1) - bit_idx_p1] | cursor_on);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            text_addr_q    <= '0;
            in_area_p0_q   <= 1'b0;
            glyph_row_p0_q <= '0;
            font_addr_q    <= '0;
            in_area_p1_q   <= 1'b0;
            rgb_q          <= COLOR_BLACK;
        end else begin
            text_addr_q    <= text_addr_d;
            in_area_p0_q   <= in_area_p0_d;
            glyph_row_p0_q <= glyph_row_p0_d;
            font_addr_q    <= font_addr_d;
            in_area_p1_q   <= in_area_p0_q;
            rgb_q          <= rgb_d;
        end
    end

    // video_on and the pixel-in-glyph index are consumed at S2, two registers on
    sync_delay_line #(.STAGES(2), .DATA_W(1 + BIT_W), .RST_VAL('0)) u_pix_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({video_on, pixel_x[BIT_W-1:0]}),
        .dout  ({vld_p1, bit_idx_p1})
    );

    sync_delay_line #(.STAGES(3), .DATA_W(2), .RST_VAL(2'b11)) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({hsync_in, vsync_in}),
        .dout  (sync_out)
    );

`ifdef TEXT_CURSOR_EN
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic               cur_hit_p0_d, cur_hit_p0_q, cur_hit_p1_q;
    logic               vsync_prev_q;
    logic [FRAME_W-1:0] frame_cnt_d, frame_cnt_q;
    logic               blink_d, blink_q;

    always_comb begin
        cur_hit_p0_d = (col == cursor_col) && (row == cursor_row) &&
                       (pixel_y[ROW_W-1:0] >= ROW_W'(CHAR_H - 2));
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;
        if (vsync_prev_q && !vsync_in) begin
            if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_hit_p0_q <= 1'b0;
            cur_hit_p1_q <= 1'b0;
            vsync_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
        end else begin
            cur_hit_p0_q <= cur_hit_p0_d;
            cur_hit_p1_q <= cur_hit_p0_q;
            vsync_prev_q <= vsync_in;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
        end
    end

    assign cursor_on   = cur_hit_p1_q & blink_q;
    assign unused_bits = pixel_y[9];
`else
    assign cursor_on   = 1'b0;
    assign unused_bits = ^{pixel_y[9], cursor_col, cursor_row, BLINK_FRAMES[0]};
`endif

    assign text_addr = text_addr_q;
    assign font_addr = font_addr_q;
    assign rgb       = rgb_q;
    assign hsync_out = sync_out[1];
    assign vsync_out = sync_out[0];

endmodule

// File: tb/tb_text_pixel_gen.sv
// Scoreboard bench for text_pixel_gen: randomized and directed scan vectors checked
// against a cell/glyph reference model built from the RAM/ROM contents.
module tb_text_pixel_gen;
    import text_vga_pkg::*;

    localparam rgb444_t FG    = 12'hFFF;
    localparam rgb444_t BG    = 12'h000;
    localparam int      BLINK = 2;
`ifdef TEXT_CURSOR_EN
    localparam bit CURSOR = 1'b1;
`else
    localparam bit CURSOR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic [11:0] text_addr;
    logic [6:0]  text_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;

    text_pixel_gen #(
        .COLS(80), .ROWS(30), .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .text_addr(text_addr), .text_data(text_data), .font_addr(font_addr),
        .font_data(font_data), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    logic [6:0] text_mem [4096];
    logic [7:0] font_mem [2048];
    assign text_data = text_mem[text_addr];
    assign font_data = font_mem[font_addr];

    typedef struct { int due; logic [11:0] val; } exp_t;
    typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; } pix_t;
    exp_t q_ta[$];
    exp_t q_fa[$];
    pix_t q_px[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   falls = 0;
    logic last_vs = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic rgb444_t model_rgb(input int px, input int py, input bit von,
                                          input int ccol, input int crow, input bit phase);
        int col = px / 8;
        int row = (py / 16) % 32;
        int gr  = py % 16;
        logic [7:0] glyph;
        bit lit;
        if (!von) return 12'h000;
        if (!(col < 80 && row < 30)) return BG;
        glyph = font_mem[text_mem[row * 80 + col] * 16 + gr];
        lit   = glyph[7 - (px % 8)];
        if (CURSOR && col == ccol && row == crow && gr >= 14 && phase) lit = 1'b1;
        return lit ? FG : BG;
    endfunction

    task automatic apply(input int px, input int py, input bit von, input bit hs,
                         input bit vs, input int ccol, input int crow, input bit push);
        int ta;
        bit phase;
        pixel_x = 10'(px); pixel_y = 10'(py); video_on = von;
        hsync_in = hs; vsync_in = vs;
        cursor_col = 7'(ccol); cursor_row = 5'(crow);
        if (last_vs && !vs) falls++;
        last_vs = vs;
        phase = ((falls / BLINK) % 2) == 1;
        if (push) begin
            ta = ((py / 16) % 32) * 80 + px / 8;
            q_ta.push_back('{cyc + 1, 12'(ta)});
            q_fa.push_back('{cyc + 2, 12'(text_mem[ta] * 16 + (py % 16))});
            q_px.push_back('{cyc + 3, model_rgb(px, py, von, ccol, crow, phase), hs, vs});
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        pix_t p;
        while (q_ta.size() > 0 && q_ta[0].due <= cyc) begin
            e = q_ta.pop_front();
            if (e.due == cyc) check("text_addr", text_addr, e.val);
            else check("text_addr_late", 12'(e.due), 12'(cyc));
        end
        while (q_fa.size() > 0 && q_fa[0].due <= cyc) begin
            e = q_fa.pop_front();
            if (e.due == cyc) check("font_addr", {1'b0, font_addr}, e.val);
            else check("font_addr_late", 12'(e.due), 12'(cyc));
        end
        while (q_px.size() > 0 && q_px[0].due <= cyc) begin
            p = q_px.pop_front();
            if (p.due == cyc) begin
                check("rgb", rgb, p.rgb);
                check("hsync_out", {11'd0, hsync_out}, {11'd0, p.hs});
                check("vsync_out", {11'd0, vsync_out}, {11'd0, p.vs});
            end else begin
                check("pixel_late", 12'(p.due), 12'(cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, rgb, 12'h000);
        check({tag, "_hsync"}, {11'd0, hsync_out}, 12'd1);
        check({tag, "_vsync"}, {11'd0, vsync_out}, 12'd1);
        check({tag, "_text_addr"}, text_addr, 12'd0);
        check({tag, "_font_addr"}, {1'b0, font_addr}, 12'd0);
    endtask

    int rnd_vs;
    logic [7:0] smiley [16] = '{8'h00, 8'h00, 8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99,
                                8'h42, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        for (int i = 0; i < 4096; i++) text_mem[i] = 7'($urandom);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            font_mem[i]      = 8'h00;
            font_mem[16 + i] = smiley[i];
            font_mem[32 + i] = 8'hFF;
        end
        text_mem[0]   = 7'h01;
        text_mem[1]   = 7'h02;
        text_mem[2]   = 7'h00;
        text_mem[163] = 7'h00;

        // Reset held while inputs toggle
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
            video_on = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            #3 check_reset_outputs("reset_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_vs = 1'b1;
        falls = 0;

        apply(639, 479, 1, 1, 1, 0, 0, 1);
        apply(8, 16, 1, 1, 1, 0, 0, 1);
        for (int x = 0; x < 8; x++) apply(x, 4, 1, 1, 1, 0, 0, 1);
        for (int x = 16; x < 24; x++) apply(x, $urandom_range(0, 15), 1, 1, 1, 0, 0, 1);
        for (int x = 8; x < 16; x++) apply(x, 0, 0, 1, 1, 0, 0, 1);
        for (int x = 8; x < 16; x++) apply(x, 0, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 96; i++) apply($urandom_range(0, 639), 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 1, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            rnd_vs = CURSOR ? 1 : int'($urandom_range(0, 1));
            apply($urandom_range(0, 1023), $urandom_range(0, 520), ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 1), rnd_vs[0], $urandom_range(0, 79), $urandom_range(0, 29), 1);
        end

        // Asynchronous reset in mid-flight with non-reset outputs in the pipe
        for (int i = 0; i < 4; i++) apply(i, 4, 1, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        q_ta.delete(); q_fa.delete(); q_px.delete();
        falls = 0; last_vs = 1'b1;
        #1 check_reset_outputs("reset_async");
        @(posedge clk); #1;
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            rnd_vs = CURSOR ? 1 : int'($urandom_range(0, 1));
            apply($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom),
                  $urandom_range(0, 1), rnd_vs[0], $urandom_range(0, 79), $urandom_range(0, 29), 1);
        end

        // Six frames over the cursor cell (3,2), glyph row 14
        for (int f = 0; f < 6; f++) begin
            for (int x = 24; x < 32; x++) apply(x, 46, 1, 1, 1, 3, 2, 1);
            for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 1, 3, 2, 1);
            for (int i = 0; i < 2; i++) apply(0, 0, 0, 1, 0, 3, 2, 1);
            for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 1, 3, 2, 1);
        end

        for (int i = 0; i < 6; i++) apply(0, 0, 0, 1, 1, 0, 0, 0);
        check("queues_drained", 12'(q_ta.size() + q_fa.size() + q_px.size()), 12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
